// File: rtl/muldiv_unit_if.sv
// Core-side request/result bundle for the iterative multiply/divide unit.
// The core drives requests and MTHI/MTLO writes; the unit returns status and HI/LO.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One bit per cycle on unsigned magnitudes; signs are applied in a single fix-up cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_start_ok;
  logic               w_iter;
  logic               w_commit;

  logic               r_is_div;
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_b_zero;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [WIDTH-1:0]   r_a_raw;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dbz;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH+1:0]   w_rem_sh;
  logic [WIDTH+1:0]   w_diff;
  logic               w_ge;
  logic [WIDTH:0]     w_div_rem;
  logic [WIDTH-1:0]   w_div_quo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rmd;

  assign w_start_ok = (r_state == IDLE) && bus.start && !bus.cancel;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_iter   = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_next = CALC;
        end
      end
      CALC: begin
        if (bus.cancel) begin
          w_next = IDLE;
        end else begin
          w_iter = 1'b1;
          if (r_cnt == LAST) begin
            w_next = FIX;
          end
        end
      end
      FIX: begin
        w_next   = IDLE;
        w_commit = !bus.cancel;
      end
      default: w_next = IDLE;
    endcase
  end

  // Magnitudes: MIN maps to 2^(WIDTH-1), which is still representable unsigned.
  always_comb begin
    w_abs_a = (bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    w_abs_b = (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // Multiply: multiplier sits in the low half and is consumed LSB-first.
  always_comb begin
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_mag_a : '0)};
    w_mul_next = {w_sum, r_acc[WIDTH-1:1]};
  end

  // Divide: dividend occupies the low half and is shifted out MSB-first as quotient bits enter.
  always_comb begin
    w_rem_sh  = {r_rem, r_acc[WIDTH-1]};
    w_diff    = w_rem_sh - {2'b00, r_mag_b};
    w_ge      = !w_diff[WIDTH+1];
    w_div_rem = w_ge ? w_diff[WIDTH:0] : w_rem_sh[WIDTH:0];
    w_div_quo = {r_acc[WIDTH-2:0], w_ge};
  end

  always_comb begin
    w_prod = r_sign_q ? -r_acc : r_acc;
    w_quo  = r_sign_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rmd  = r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_is_div <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_b_zero <= 1'b0;
      r_cnt    <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_a_raw  <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_start_ok) begin
        r_is_div <= bus.op[1];
        r_sign_q <= bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        r_sign_r <= bus.op[0] & bus.a[WIDTH-1];
        r_b_zero <= (bus.b == '0);
        r_cnt    <= '0;
        r_mag_a  <= w_abs_a;
        r_mag_b  <= w_abs_b;
        r_a_raw  <= bus.a;
        r_acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? w_abs_a : w_abs_b)};
        r_rem    <= '0;
        r_dbz    <= 1'b0;
      end else if (r_state == IDLE) begin
        if (bus.hi_we) begin
          r_hi <= bus.wdata;
        end
        if (bus.lo_we) begin
          r_lo <= bus.wdata;
        end
      end

      if (w_iter) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_is_div) begin
          r_acc <= {r_acc[2*WIDTH-1:WIDTH], w_div_quo};
          r_rem <= w_div_rem;
        end else begin
          r_acc <= w_mul_next;
        end
      end

      if (w_commit) begin
        if (!r_is_div) begin
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end else if (r_b_zero) begin
          r_hi  <= r_a_raw;
          r_lo  <= '1;
          r_dbz <= 1'b1;
        end else begin
          r_hi <= w_rmd;
          r_lo <= w_quo;
        end
      end
    end
  end

  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a cycle-count/arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed HI/LO literals.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk;
  logic reset;
  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {div_by_zero, hi, lo}.
  function automatic logic [64:0] model_result(input logic [1:0] op,
                                                input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin
        p = {32'b0, a} * {32'b0, b};
        return {1'b0, p};
      end
      2'b01: begin
        p = 64'(sa * sb);
        return {1'b0, p};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (op == 2'b10) return {1'b0, a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  logic        m_busy, m_done, m_dbz;
  logic [31:0] m_hi, m_lo;
  logic [64:0] m_res;
  int          m_left;

  // Timing model: an accepted op occupies WIDTH+1 cycles, then commits with a done pulse.
  always @(posedge clk) begin
    if (!reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_left <= 0;
    end else if (m_busy) begin
      if (bus.cancel) begin
        m_busy <= 1'b0; m_done <= 1'b0;
      end else if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        m_hi <= m_res[63:32]; m_lo <= m_res[31:0]; m_dbz <= m_res[64];
      end else begin
        m_left <= m_left - 1; m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (bus.start && !bus.cancel) begin
        m_busy <= 1'b1;
        m_left <= W + 1;
        m_res  <= model_result(bus.op, bus.a, bus.b);
        m_dbz  <= 1'b0;
      end else begin
        if (bus.hi_we) m_hi <= bus.wdata;
        if (bus.lo_we) m_lo <= bus.wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", {31'b0, bus.busy}, {31'b0, m_busy});
      cmp("done", {31'b0, bus.done}, {31'b0, m_done});
      cmp("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, m_dbz});
      cmp("hi", bus.hi, m_hi);
      cmp("lo", bus.lo, m_lo);
    end
  end

  task automatic wait_done(output int bcyc);
    bit seen;
    seen = 1'b0;
    bcyc = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else if (bus.busy) bcyc++;
    end
    if (!seen) cmp("done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #2;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int bcyc);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk);
    #2 bus.start = 1'b0;
    wait_done(bcyc);
  endtask

  int n;

  initial begin
    reset = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    @(posedge clk);
    #2 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    cmp("reset_hi", bus.hi, 32'h0);
    cmp("reset_lo", bus.lo, 32'h0);
    cmp("reset_busy", {31'b0, bus.busy}, 32'h0);

    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    cmp("multu_busy_cycles", n, 32'd33);
    cmp("multu_hi", bus.hi, 32'hFFFF_FFFE);
    cmp("multu_lo", bus.lo, 32'h0000_0001);

    do_op(2'b01, 32'hFFFF_FFFD, 32'd7, n);
    cmp("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
    cmp("mult_neg_lo", bus.lo, 32'hFFFF_FFEB);
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, n);
    cmp("mult_minmin_hi", bus.hi, 32'h4000_0000);
    cmp("mult_minmin_lo", bus.lo, 32'h0000_0000);

    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, n);
    cmp("div_m7_2_lo", bus.lo, 32'hFFFF_FFFD);
    cmp("div_m7_2_hi", bus.hi, 32'hFFFF_FFFF);
    do_op(2'b11, 32'd7, 32'hFFFF_FFFE, n);
    cmp("div_7_m2_lo", bus.lo, 32'hFFFF_FFFD);
    cmp("div_7_m2_hi", bus.hi, 32'h0000_0001);
    do_op(2'b10, 32'd7, 32'd2, n);
    cmp("divu_7_2_lo", bus.lo, 32'd3);
    cmp("divu_7_2_hi", bus.hi, 32'd1);

    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, n);
    cmp("div_ovf_lo", bus.lo, 32'h8000_0000);
    cmp("div_ovf_hi", bus.hi, 32'h0);
    cmp("div_ovf_dbz", {31'b0, bus.div_by_zero}, 32'd0);
    do_op(2'b10, 32'h1234_5678, 32'd0, n);
    cmp("divz_busy_cycles", n, 32'd33);
    cmp("divz_lo", bus.lo, 32'hFFFF_FFFF);
    cmp("divz_hi", bus.hi, 32'h1234_5678);
    cmp("divz_dbz", {31'b0, bus.div_by_zero}, 32'd1);
    bus.op = 2'b10; bus.a = 32'd7; bus.b = 32'd2; bus.start = 1'b1;
    @(posedge clk);
    #2 bus.start = 1'b0;
    cmp("dbz_cleared_on_start", {31'b0, bus.div_by_zero}, 32'd0);
    wait_done(n);

    // Cancel sampled at E10 of a MULTU; prior HI/LO (1, 3) must survive.
    bus.op = 2'b00; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.start = 1'b1;
    @(posedge clk);
    #2 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2 bus.cancel = 1'b1;
    @(posedge clk);
    #2 bus.cancel = 1'b0;
    cmp("cancel_busy", {31'b0, bus.busy}, 32'd0);
    cmp("cancel_hi", bus.hi, 32'd1);
    cmp("cancel_lo", bus.lo, 32'd3);
    repeat (30) @(posedge clk);
    #2;

    // Start and MTHI/MTLO during busy are ignored.
    bus.op = 2'b00; bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
    @(posedge clk);
    #2 bus.op = 2'b01; bus.a = 32'd5; bus.b = 32'd5;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    repeat (5) @(posedge clk);
    #2 bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    wait_done(n);
    cmp("busy_ignore_hi", bus.hi, 32'd0);
    cmp("busy_ignore_lo", bus.lo, 32'd6);

    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    #2 bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    cmp("mthi", bus.hi, 32'hA5A5_A5A5);
    cmp("mtlo", bus.lo, 32'hA5A5_A5A5);

    // start wins over a simultaneous MTHI.
    bus.op = 2'b00; bus.a = 32'd1; bus.b = 32'd1; bus.start = 1'b1;
    bus.hi_we = 1'b1; bus.wdata = 32'hFFFF_0000;
    @(posedge clk);
    #2 bus.start = 1'b0; bus.hi_we = 1'b0;
    wait_done(n);
    cmp("start_wins_hi", bus.hi, 32'd0);
    cmp("start_wins_lo", bus.lo, 32'd1);

    // Reset at E20 of a DIV.
    bus.op = 2'b11; bus.a = 32'hFFFF_FF9C; bus.b = 32'd7; bus.start = 1'b1;
    @(posedge clk);
    #2 bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    cmp("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
    cmp("rst_mid_done", {31'b0, bus.done}, 32'd0);
    cmp("rst_mid_lo", bus.lo, 32'd0);
    cmp("rst_mid_hi", bus.hi, 32'd0);

    bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd3; bus.start = 1'b1; bus.cancel = 1'b1;
    @(posedge clk);
    #2 bus.start = 1'b0; bus.cancel = 1'b0;
    cmp("start_cancel_busy", {31'b0, bus.busy}, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
